// File: rtl/dbus_ctrl_pkg.sv
// dbus_ctrl_pkg: shared encodings and helpers for the MEM-stage data-bus controller.
// Controller state encodings, reset/stall polarities and the address alignment helper.
package dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    DbusIdle = 2'd0,
    DbusBusy = 2'd1,
    DbusDone = 2'd2
  } dbus_state_e;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;

  // The bus is word addressed; byte position is carried by the byte enables.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dbus_ctrl_if.sv
// dbus_ctrl_if: external data-bus request/acknowledge signals.
// master = the controller, slave = the memory/peripheral side.
interface dbus_ctrl_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/dbus_wdog.sv
// dbus_wdog: BUSY-cycle watchdog for dbus_ctrl.
// Counts enabled cycles from a clear; o_expire is high in the cycle whose end
// makes the count reach TIMEOUT, so the caller can abort on that edge.
module dbus_wdog
  import dbus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;

  // Count BUSY cycles; cleared whenever the controller is outside BUSY.
  always_ff @(posedge clk) begin
    if (rst == RstEnable)  r_cnt <= '0;
    else if (i_clr)        r_cnt <= '0;
    else if (i_en)         r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en && (r_cnt == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: MEM-stage load/store to multi-cycle req/ack data-bus transaction.
// Stalls the pipeline from the issuing IDLE cycle through BUSY; DONE is the
// retiring cycle. Optional watchdog abort built when DBUS_TIMEOUT_EN is defined.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  dbus_ctrl_if.master bus
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("dbus_ctrl: TIMEOUT must be at least 1");
  end

  dbus_state_e r_state, w_next;
  logic        w_stallreq, w_start, w_finish, w_expire;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_sel;

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_state <= DbusIdle;
    else                  r_state <= w_next;
  end

  // Next state and stall request; stall never looks at the ack.
  always_comb begin
    w_next     = r_state;
    w_stallreq = NoStop;
    w_start    = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      DbusIdle: begin
        if (mem_ce_i) begin
          w_stallreq = Stop;
          w_start    = 1'b1;
          w_next     = DbusBusy;
        end
      end
      DbusBusy: begin
        w_stallreq = Stop;
        if (bus.bus_ack_i || w_expire) begin
          w_finish = 1'b1;
          w_next   = DbusDone;
        end
      end
      DbusDone: w_next = DbusIdle;
      default:  w_next = DbusIdle;
    endcase
  end

  // Bus request registers: loaded on issue, held through BUSY; data captured on finish.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= ZeroWord;
      r_sel   <= 4'b0000;
      r_wdata <= ZeroWord;
      r_rdata <= ZeroWord;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= mem_we_i;
      r_addr  <= word_align(mem_addr_i);
      r_sel   <= mem_sel_i;
      r_wdata <= mem_data_i;
    end else if (w_finish) begin
      r_req   <= 1'b0;
      // Stores and watchdog aborts return zero; an ack on the expiry edge wins.
      r_rdata <= (bus.bus_ack_i && !r_we) ? bus.bus_rdata_i : ZeroWord;
    end
  end

`ifdef DBUS_TIMEOUT_EN
  logic r_err;

  dbus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != DbusBusy),
    .i_en     (r_state == DbusBusy),
    .o_expire (w_expire)
  );

  // Error pulse covers exactly the DONE cycle of an aborted access.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_err <= 1'b0;
    else                  r_err <= w_finish && !bus.bus_ack_i;
  end

  assign bus.bus_err_o = r_err;
`else
  assign w_expire      = 1'b0;
  assign bus.bus_err_o = 1'b0;
`endif

  assign stallreq_o      = w_stallreq;
  assign mem_data_o      = (r_state == DbusDone) ? r_rdata : ZeroWord;
  assign bus.bus_req_o   = r_req;
  assign bus.bus_we_o    = r_we;
  assign bus.bus_addr_o  = r_addr;
  assign bus.bus_sel_o   = r_sel;
  assign bus.bus_wdata_o = r_wdata;

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: randomized accesses checked every cycle against a transaction-level
// timeline model (issue, ack delay, DONE), plus literal checks of the directed cases.
// Watchdog cases are compiled when DBUS_TIMEOUT_EN is defined.
module tb_dbus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ce_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic        stallreq_o;

  dbus_ctrl_if bus_if ();

  dbus_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .stallreq_o (stallreq_o),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle, written by the stimulus.
  logic        e_on = 1'b0, e_stall, e_req, e_chk, e_we, e_err, e_done, e_first;
  logic [31:0] e_addr, e_wdata, e_mdata;
  logic [3:0]  e_sel;

  int n_cmp = 0, n_bad = 0;

  // Observations for the literal checks (written only by the compare process).
  int          obs_stall = 0, run_low = 0, last_gap = -1;
  logic [31:0] obs_data = '0, obs_addr = '0;
  logic        obs_err = 1'b0, obs_we = 1'b0;
  logic [3:0]  obs_sel = '0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_on) begin
      cmp("stallreq_o", 32'(stallreq_o), 32'(e_stall));
      cmp("bus_req_o", 32'(bus_if.bus_req_o), 32'(e_req));
      cmp("mem_data_o", mem_data_o, e_mdata);
      cmp("bus_err_o", 32'(bus_if.bus_err_o), 32'(e_err));
      if (e_chk) begin
        cmp("bus_we_o", 32'(bus_if.bus_we_o), 32'(e_we));
        cmp("bus_addr_o", bus_if.bus_addr_o, e_addr);
        cmp("bus_sel_o", 32'(bus_if.bus_sel_o), 32'(e_sel));
        cmp("bus_wdata_o", bus_if.bus_wdata_o, e_wdata);
      end
      if (stallreq_o) obs_stall++;
      if (e_done) begin
        obs_data = mem_data_o;
        obs_err  = bus_if.bus_err_o;
      end
      if (e_first) begin
        obs_addr = bus_if.bus_addr_o;
        obs_we   = bus_if.bus_we_o;
        obs_sel  = bus_if.bus_sel_o;
      end
      if (bus_if.bus_req_o) begin
        if (run_low > 0) last_gap = run_low;
        run_low = 0;
      end else begin
        run_low++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input logic st, input logic rq, input logic chk, input logic we,
                              input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                              input logic [31:0] md, input logic er, input logic dn, input logic fs);
    e_on = 1'b1; e_stall = st; e_req = rq; e_chk = chk; e_we = we; e_addr = a; e_sel = s;
    e_wdata = wd; e_mdata = md; e_err = er; e_done = dn; e_first = fs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      mem_ce_i = 1'b0;
      bus_if.bus_ack_i   = 1'($urandom_range(0, 1));
      bus_if.bus_rdata_i = $urandom();
      expect_cycle(0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0);
    end
  endtask

  // One access whose ack comes n cycles after bus_req_o rises (none if the watchdog fires first).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, input int n, input logic [31:0] rd);
    int          last;
    logic        to;
    logic [31:0] a;
    a = addr & ~32'd3;
`ifdef DBUS_TIMEOUT_EN
    to   = (n >= int'(TO));
    last = to ? int'(TO) : n + 1;
`else
    to   = 1'b0;
    last = n + 1;
`endif
    tick();
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wd;
    bus_if.bus_ack_i   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata_i = $urandom();
    expect_cycle(1, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0);
    for (int k = 1; k <= last; k++) begin
      tick();
      bus_if.bus_ack_i   = !to && (k == n + 1);
      bus_if.bus_rdata_i = (k == last) ? rd : $urandom();
      expect_cycle(1, 1, 1, we, a, sel, wd, '0, 0, 0, k == 1);
    end
    tick();
    bus_if.bus_ack_i   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata_i = $urandom();
    expect_cycle(0, 0, 0, 0, '0, '0, '0, (to || we) ? 32'h0 : rd, to, 1, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    bus_if.bus_ack_i   = 1'b0;
    bus_if.bus_rdata_i = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // Reset state: everything zero, bus fields included.
    expect_cycle(0, 0, 1, 0, '0, '0, '0, '0, 0, 0, 0);
    idle(1);

    // Load, ack 2 cycles after request.
    s0 = obs_stall;
    do_access(0, 32'h0000_0100, 4'hF, 32'h0, 2, 32'hDEADBEEF);
    cmp("load_stall_cycles", 32'(obs_stall - s0), 32'd4);
    cmp("load_data", obs_data, 32'hDEADBEEF);
    idle(1);

    // Store with unaligned address.
    do_access(1, 32'h8000_0007, 4'b0011, 32'h0000_1234, 1, 32'hCAFEF00D);
    cmp("store_addr", obs_addr, 32'h8000_0004);
    cmp("store_we", 32'(obs_we), 32'd1);
    cmp("store_sel", 32'(obs_sel), 32'd3);
    cmp("store_done_data", obs_data, 32'h0);
    idle(2);

    // Zero-wait back to back: gap = DONE cycle + one IDLE cycle.
    s0 = obs_stall;
    do_access(0, 32'h0000_0040, 4'hF, 32'h0, 0, 32'h1111_1111);
    cmp("zw1_stall_cycles", 32'(obs_stall - s0), 32'd2);
    cmp("zw1_data", obs_data, 32'h1111_1111);
    s0 = obs_stall;
    do_access(0, 32'h0000_0044, 4'hF, 32'h0, 0, 32'h2222_2222);
    cmp("zw2_stall_cycles", 32'(obs_stall - s0), 32'd2);
    cmp("zw2_data", obs_data, 32'h2222_2222);
    cmp("b2b_req_low_gap", 32'(last_gap), 32'd2);
    idle(1);

    // Reset in the 3rd BUSY cycle, then a stale ack.
    tick();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200; mem_sel_i = 4'hF; mem_data_i = 32'h5555;
    bus_if.bus_ack_i = 1'b0;
    expect_cycle(1, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus_if.bus_ack_i = 1'b0;
      rst = (k == 3);
      expect_cycle(1, 1, 1, 0, 32'h200, 4'hF, 32'h5555, '0, 0, 0, k == 1);
    end
    tick();
    rst = 1'b0; mem_ce_i = 1'b0;
    bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hFFFF_0000;
    expect_cycle(0, 0, 1, 0, '0, '0, '0, '0, 0, 0, 0);
    tick();
    bus_if.bus_ack_i = 1'b0;
    expect_cycle(0, 0, 1, 0, '0, '0, '0, '0, 0, 0, 0);
    idle(1);

`ifdef DBUS_TIMEOUT_EN
    // No ack: abort after TO BUSY cycles.
    s0 = obs_stall;
    do_access(0, 32'h0000_0300, 4'hF, 32'h0, 1000, 32'hBAD0BAD0);
    cmp("wdog_stall_cycles", 32'(obs_stall - s0), 32'd5);
    cmp("wdog_err", 32'(obs_err), 32'd1);
    cmp("wdog_data", obs_data, 32'h0);
    idle(1);
    // Ack on the expiry edge wins.
    s0 = obs_stall;
    do_access(0, 32'h0000_0304, 4'hF, 32'h0, 3, 32'h600DF00D);
    cmp("wdog_race_stall_cycles", 32'(obs_stall - s0), 32'd5);
    cmp("wdog_race_err", 32'(obs_err), 32'd0);
    cmp("wdog_race_data", obs_data, 32'h600DF00D);
    idle(1);
`else
    // Without the watchdog BUSY waits as long as it takes.
    s0 = obs_stall;
    do_access(0, 32'h0000_0300, 4'hF, 32'h0, 40, 32'h7777_ABCD);
    cmp("long_stall_cycles", 32'(obs_stall - s0), 32'd42);
    cmp("long_err", 32'(obs_err), 32'd0);
    cmp("long_data", obs_data, 32'h7777_ABCD);
    idle(1);
`endif

    // Randomized accesses with random ack delays and gaps.
    for (int i = 0; i < 150; i++) begin
      do_access(1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), $urandom(),
                int'($urandom_range(0, 6)), $urandom());
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    e_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
